// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB/HALT sequencer with output decode.
// Outputs are decoded from the registered state (plus opcode, and zero for PCSrc only).
module multi_cycle_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [2:0] state,
  output logic [2:0] ALUOp,
  output logic       ALUSrcB,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       RegDst,
  output logic       WrRegData,
  output logic       ExtSel,
  output logic [1:0] PCSrc
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e state_q, state_d;
  // Cleared by reset so every enable stays low until the first clock after release.
  logic   active_q, active_d;

  logic is_rtype_s, is_sw_s, is_lw_s, is_beq_s, is_j_s, is_halt_s, is_ori_s;
  logic is_imm_s, is_legal_s;

  assign is_rtype_s = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_OR)  || (opcode == OP_AND);
  assign is_sw_s    = (opcode == OP_SW);
  assign is_lw_s    = (opcode == OP_LW);
  assign is_beq_s   = (opcode == OP_BEQ);
  assign is_j_s     = (opcode == OP_J);
  assign is_halt_s  = (opcode == OP_HALT);
  assign is_ori_s   = (opcode == OP_ORI);
  assign is_imm_s   = (opcode == OP_ADDI) || is_ori_s || is_sw_s || is_lw_s;
  assign is_legal_s = is_rtype_s || is_imm_s || is_beq_s || is_j_s || is_halt_s;

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_SUB, OP_BEQ: res = 3'b001;
      OP_OR,  OP_ORI: res = 3'b011;
      OP_AND:         res = 3'b100;
      default:        res = 3'b000;
    endcase
    return res;
  endfunction

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    active_d = 1'b1;
    case (state_q)
      S_IF: begin
        if (active_q) state_d = S_ID;
        else          state_d = S_IF;
      end
      S_ID: begin
        if (is_halt_s)                   state_d = S_HALT;
        else if (is_j_s || !is_legal_s)  state_d = S_IF;
        else                             state_d = S_EXE;
      end
      S_EXE: begin
        if (is_beq_s)                state_d = S_IF;
        else if (is_sw_s || is_lw_s) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        if (is_lw_s) state_d = S_WB;
        else         state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IF;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  // Output decode of the registered state.
  always_comb begin
    ALUOp     = 3'b000;
    ALUSrcB   = 1'b0;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    RegDst    = is_rtype_s;
    WrRegData = is_lw_s;
    ExtSel    = !is_ori_s;
    if (active_q) begin
      ALUOp   = alu_op_of(opcode);
      ALUSrcB = is_imm_s;
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          // j and illegal opcodes retire here; halt does not.
          PCWre = is_j_s || !is_legal_s;
          if (is_j_s) PCSrc = 2'b10;
          else        PCSrc = 2'b00;
        end
        S_EXE: begin
          PCWre = is_beq_s;
          if (is_beq_s && zero) PCSrc = 2'b01;
          else                  PCSrc = 2'b00;
        end
        S_MEM: begin
          PCWre = is_sw_s;
          mRD   = is_lw_s;
          mWR   = is_sw_s;
        end
        S_WB: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        S_HALT:  PCWre = 1'b0;
        default: PCWre = 1'b0;
      endcase
    end else begin
      IRWre = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-cycle expected output vectors via a scoreboard queue.
module tb_multi_cycle_ctrl;

  logic       CLK;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state;
  logic [2:0] ALUOp;
  logic       ALUSrcB, PCWre, IRWre, RegWre, mRD, mWR, RegDst, WrRegData, ExtSel;
  logic [1:0] PCSrc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] aluop;
    logic       alusrcb;
    logic       pcwre;
    logic       irwre;
    logic       regwre;
    logic       mrd;
    logic       mwr;
    logic       regdst;
    logic       wrregdata;
    logic       extsel;
    logic [1:0] pcsrc;
  } vec_t;

  vec_t sb_q[$];

  multi_cycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .state(state), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCWre(PCWre),
    .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .RegDst(RegDst),
    .WrRegData(WrRegData), .ExtSel(ExtSel), .PCSrc(PCSrc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference behaviour for one cycle, written from the control table.
  function automatic vec_t model(input logic act, input logic [2:0] st,
                                 input logic [5:0] op, input logic z);
    vec_t v;
    logic r_type, imm, legal;
    r_type = (op == 6'b000000) || (op == 6'b000001) || (op == 6'b010000) || (op == 6'b010001);
    imm    = (op == 6'b000010) || (op == 6'b010010) || (op == 6'b100110) || (op == 6'b100111);
    legal  = r_type || imm || (op == 6'b110000) || (op == 6'b111000) || (op == 6'b111111);
    v = '0;
    v.st        = st;
    v.regdst    = r_type;
    v.wrregdata = (op == 6'b100111);
    v.extsel    = (op != 6'b010010);
    if (act) begin
      if (op == 6'b000001 || op == 6'b110000)      v.aluop = 3'b001;
      else if (op == 6'b010000 || op == 6'b010010) v.aluop = 3'b011;
      else if (op == 6'b010001)                    v.aluop = 3'b100;
      else                                         v.aluop = 3'b000;
      v.alusrcb = imm;
      v.irwre   = (st == 3'b000);
      v.regwre  = (st == 3'b100);
      v.mrd     = (st == 3'b011) && (op == 6'b100111);
      v.mwr     = (st == 3'b011) && (op == 6'b100110);
      v.pcwre   = ((st == 3'b001) && ((op == 6'b111000) || !legal)) ||
                  ((st == 3'b010) && (op == 6'b110000)) ||
                  ((st == 3'b011) && (op == 6'b100110)) ||
                  (st == 3'b100);
      if ((st == 3'b001) && (op == 6'b111000))            v.pcsrc = 2'b10;
      else if ((st == 3'b010) && (op == 6'b110000) && z)  v.pcsrc = 2'b01;
      else                                                v.pcsrc = 2'b00;
    end
    return v;
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    v = {state, ALUOp, ALUSrcB, PCWre, IRWre, RegWre, mRD, mWR, RegDst, WrRegData, ExtSel, PCSrc};
    return v;
  endfunction

  task automatic check_vec(input string tag, input int idx);
    vec_t e, a;
    a = dut_vec();
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s[%0d]: observed %h expected <scoreboard entry>", tag, idx, a);
    end else begin
      e = sb_q.pop_front();
      assert (a === e) else begin
        errors++;
        $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, a, e);
      end
    end
  endtask

  // Drives one instruction; seq lists the expected states, first state in the low bits.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                           input int n, input logic [47:0] seq);
    opcode = op;
    zero   = z;
    for (int i = 0; i < n; i++) sb_q.push_back(model(1'b1, seq[3*i +: 3], op, z));
    for (int i = 0; i < n; i++) begin
      #1;
      check_vec(tag, i);
      @(negedge CLK);
    end
  endtask

  initial begin
    Reset  = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;
    #2;
    sb_q.push_back(model(1'b0, 3'b000, opcode, zero));
    check_vec("reset", 0);
    @(negedge CLK);
    #1;
    sb_q.push_back(model(1'b0, 3'b000, opcode, zero));
    check_vec("reset_hold", 0);
    Reset = 1'b1;
    @(negedge CLK);

    run_instr("add",     6'b000000, 1'b1,  4, {36'd0, 3'd4, 3'd2, 3'd1, 3'd0});
    run_instr("lw",      6'b100111, 1'b0,  5, {33'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    run_instr("beq_z1",  6'b110000, 1'b1,  3, {39'd0, 3'd2, 3'd1, 3'd0});
    run_instr("beq_z0",  6'b110000, 1'b0,  3, {39'd0, 3'd2, 3'd1, 3'd0});
    run_instr("j",       6'b111000, 1'b1,  2, {42'd0, 3'd1, 3'd0});
    run_instr("sw",      6'b100110, 1'b1,  4, {36'd0, 3'd3, 3'd2, 3'd1, 3'd0});
    run_instr("and",     6'b010001, 1'b0,  4, {36'd0, 3'd4, 3'd2, 3'd1, 3'd0});
    run_instr("ori",     6'b010010, 1'b1,  4, {36'd0, 3'd4, 3'd2, 3'd1, 3'd0});
    run_instr("illegal", 6'b101010, 1'b1,  2, {42'd0, 3'd1, 3'd0});
    run_instr("halt",    6'b111111, 1'b1, 12, {12'd0, {10{3'd5}}, 3'd1, 3'd0});

    // Mid-cycle reset out of HALT must act without a clock edge.
    #2;
    Reset = 1'b0;
    #1;
    sb_q.push_back(model(1'b0, 3'b000, opcode, zero));
    check_vec("halt_reset", 0);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    run_instr("add_after_halt", 6'b000000, 1'b0, 4, {36'd0, 3'd4, 3'd2, 3'd1, 3'd0});

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: observed %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of CLK.
REQ-002 CLK  input  1  system clock.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction opcode from IR, stable from ID onward.
REQ-005 zero  input  1  ALU zero flag, valid combinationally during EXE.
REQ-006 state  output  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
REQ-007 ALUOp  output  3  ALU operation: 000 add, 001 sub, 011 or, 100 and.
REQ-008 ALUSrcB  output  1  ALU B-operand select: 1 = extended immediate, 0 = register data 2.
REQ-009 PCWre, IRWre, RegWre, mRD, mWR  output  1 each  PC write, IR write, regfile write, data-memory read, data-memory write.
REQ-010 RegDst, WrRegData, ExtSel  output  1 each  destination select (1 = rd, 0 = rt), write-back source (1 = memory, 0 = ALU), sign-extend (1) or zero-extend (0).
REQ-011 PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.

Function
REQ-012 Decoded opcodes SHALL be: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sw 100110, lw 100111, beq 110000, j 111000, halt 111111.
REQ-013 Any other opcode is illegal; the block SHALL treat it as a NOP (ID -> IF, PCWre=1 in ID, PCSrc=00, no register or memory write).
REQ-014 Transitions: IF->ID always.
REQ-015 Transitions out of ID: j->IF, halt->HALT, illegal->IF, all others->EXE.
REQ-016 Transitions out of EXE: beq->IF, sw/lw->MEM, add/sub/addi/or/and/ori->WB.
REQ-017 Transitions out of MEM and WB: MEM with sw->IF, MEM with lw->WB, WB->IF.
REQ-018 HALT SHALL hold indefinitely with all write enables at 0, until Reset.
REQ-019 Instruction latency in cycles SHALL be: j 2, beq 3, sw 4, R-type and I-arith 4, lw 5.
REQ-020 IRWre SHALL be 1 only in IF.
REQ-021 PCWre SHALL be 1 for exactly one cycle per instruction: the final state of that instruction.
REQ-022 PCWre SHALL be 0 in HALT.
REQ-023 PCSrc SHALL be 10 in ID for j.
REQ-024 PCSrc SHALL be 01 in EXE for beq when zero=1, and 00 in EXE for beq when zero=0.
REQ-025 PCSrc SHALL be 00 in all other states; zero SHALL be ignored outside beq EXE.
REQ-026 ALUOp SHALL be 000 for add, addi, lw and sw; 001 for sub and beq; 011 for or and ori; 100 for and.
REQ-027 ALUOp SHALL hold its value across EXE, MEM and WB of the instruction.
REQ-028 ALUSrcB SHALL be 1 for addi, ori, lw and sw, and 0 otherwise.
REQ-029 ExtSel SHALL be 0 for ori and 1 otherwise.
REQ-030 RegDst SHALL be 1 for R-type (add, sub, or, and) and 0 otherwise.
REQ-031 RegWre SHALL be 1 only in WB.
REQ-032 WrRegData SHALL be 1 only for lw.
REQ-033 mRD SHALL be 1 only in MEM for lw, and mWR SHALL be 1 only in MEM for sw.
REQ-034 All outputs SHALL be a decode of the registered state, the opcode and, for PCSrc only, zero.
REQ-035 Outputs SHALL be glitch-free with respect to state; the next state SHALL be computed combinationally and registered.

Reset
REQ-036 Asserting Reset low SHALL, asynchronously and in any state (including mid-instruction or HALT), force state=IF.
REQ-037 While Reset is low, all enables (PCWre, IRWre, RegWre, mRD, mWR) SHALL be 0, PCSrc=00, ALUOp=000, ALUSrcB=0.
REQ-038 After Reset is released, the first rising edge of CLK SHALL leave state=IF with IRWre=1, and the first instruction SHALL begin.

Verification
REQ-039 Reset low, then release, opcode=000000 (add) -> states IF,ID,EXE,WB,IF; RegWre=1 and PCWre=1 only in WB; RegDst=1; ALUOp=000; ALUSrcB=0.
REQ-040 opcode=100111 (lw) -> states IF,ID,EXE,MEM,WB; mRD=1 in MEM; WrRegData=1 and RegWre=1 in WB; ALUSrcB=1; 5 cycles total.
REQ-041 opcode=110000 (beq) with zero=1, then again with zero=0 -> 3 cycles each; in EXE PCWre=1 and ALUOp=001 both times; PCSrc=01 in the first run and 00 in the second.
REQ-042 opcode=111000 (j) -> IF,ID,IF; PCSrc=10 and PCWre=1 in ID; RegWre, mRD and mWR stay 0 throughout.
REQ-043 opcode=111111 (halt) for 10 cycles, then Reset pulsed low mid-cycle -> state=101 held with PCWre=0; state becomes 000 immediately on Reset, without waiting for CLK.
REQ-044 opcode=010010 (ori), then opcode=101010 (illegal) -> ori: ExtSel=0, ALUOp=011, RegDst=0; illegal: IF,ID,IF with PCWre=1 in ID and no register or memory writes.
